// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter: default parameter values
// and the arbiter state encoding. The burst-lock state machine only exists
// when FIFO_ARB_BURST_EN is defined, but the encoding lives here so the debug
// state port has the same type in both builds.
package fifo_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
// Round-robin find-first-set: rotates the request vector so that index ptr
// becomes bit 0, finds the lowest set bit, and rotates the result back.
// Purely combinational.
//
// Ports:
//   req         - request vector, bit i for requester i
//   ptr         - highest-priority index for this search
//   grant       - one-hot grant (all zero when no request)
//   grant_id    - index of the granted requester (0 when no request)
//   grant_valid - high when any request was found
module rr_priority_encoder #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_id,
    output logic             grant_valid
);

    logic [N_REQ-1:0] rotated;
    logic             found;
    int               first;
    int               winner;

    always_comb begin
        rotated = '0;
        found   = 1'b0;
        first   = 0;
        winner  = 0;

        // Rotate: rotated[k] is requester (ptr + k) mod N_REQ.
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = k + int'(ptr);
            if (idx >= N_REQ) idx = idx - N_REQ;
            rotated[k] = req[idx];
        end

        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                first = k;
            end
        end

        // Un-rotate back to an absolute requester index.
        if (found) begin
            winner = first + int'(ptr);
            if (winner >= N_REQ) winner = winner - N_REQ;
        end

        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = found && (i == winner);
        end
        grant_id    = PTR_W'(winner);
        grant_valid = found;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Arbitrates N_REQ write requesters onto one shared FIFO write port using a
// registered round-robin pointer. The grant is combinational (zero latency):
// a word is accepted in any cycle where req[i] and grant[i] are both high.
// Nothing is granted while fifo_full is high or reset is asserted.
//
// Optional feature (macro FIFO_ARB_BURST_EN): burst lock. After a beat from
// requester i in IDLE the arbiter locks onto i for up to MAX_BURST beats;
// dropping req[i] releases the lock and re-arbitrates in the same cycle.
// Without the macro every beat re-arbitrates and MAX_BURST is unused.
//
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   req           - per-requester write request
//   data_in       - requester i's word in [i*WIDTH +: WIDTH]
//   fifo_full     - shared FIFO full flag
//   grant         - one-hot grant
//   grant_id      - granted requester index (0 when no grant)
//   write_request - FIFO write strobe (OR of grant)
//   fifo_data     - granted word (0 when no grant)
//   dbg_ptr       - current round-robin pointer (debug)
//   dbg_state     - current arbiter state (debug; always IDLE without burst)
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   data_in,
    input  logic                     fifo_full,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     write_request,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [$clog2(N_REQ)-1:0] dbg_ptr,
    output arb_state_e               dbg_state
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || MAX_BURST < 1) begin : g_bad_params
        $error("fifo_write_arbiter: N_REQ must be >= 2 and MAX_BURST >= 1");
    end

    function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] v);
        if (v == PTR_W'(N_REQ - 1)) return '0;
        return v + PTR_W'(1);
    endfunction

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] search_ptr;
    logic [N_REQ-1:0] arb_req;
    logic             grant_valid;

    rr_priority_encoder #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_enc (
        .req         (arb_req),
        .ptr         (search_ptr),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign write_request = grant_valid;
    assign fifo_data     = grant_valid ? data_in[int'(grant_id)*WIDTH +: WIDTH] : '0;
    assign dbg_ptr       = ptr_q;

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N_REQ-1:0] owner_mask;
    logic             holding;
    logic             released;

    assign dbg_state = state_q;

    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            owner_mask[i] = (PTR_W'(i) == owner_q);
        end

        // holding: lock continues this cycle; released: owner dropped req,
        // so the search restarts right after the owner in this same cycle.
        holding  = (state_q == LOCKED) && req[owner_q];
        released = (state_q == LOCKED) && !req[owner_q];

        search_ptr = released ? inc_wrap(owner_q) : ptr_q;
        arb_req    = holding ? (req & owner_mask) : req;
        if (reset || fifo_full) arb_req = '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        count_d = count_q;
        ptr_d   = ptr_q;

        // While full, everything holds (including a pending release).
        if (!fifo_full) begin
            if (holding) begin
                // The owner is the only eligible requester, so it is granted.
                if (count_q == CNT_W'(MAX_BURST - 1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    ptr_d   = inc_wrap(owner_q);
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                if (released) begin
                    state_d = IDLE;
                    count_d = '0;
                    ptr_d   = search_ptr;
                end
                if (grant_valid) begin
                    ptr_d = inc_wrap(grant_id);
                    // A one-beat burst limit never locks.
                    if (MAX_BURST > 1) begin
                        state_d = LOCKED;
                        owner_d = grant_id;
                        count_d = CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            state_q <= IDLE;
            owner_q <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            state_q <= state_d;
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end
`else
    assign dbg_state = IDLE;

    always_comb begin
        search_ptr = ptr_q;
        arb_req    = (reset || fifo_full) ? '0 : req;
        ptr_d      = grant_valid ? inc_wrap(grant_id) : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule
